// File: rtl/sum_seq_ctrl.sv
// Memory-walking accumulator: sums NUM_WORDS words, tracks the max, drives a display value.
// Optional saturating sum when the macro SUM_SAT_EN is defined (default: wrap).
module sum_seq_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int SUM_W     = 16,
  parameter int NUM_WORDS = 10
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum,
  output logic [DATA_W-1:0] max_val,
  output logic              ovf,
  input  logic              disp_sel,
  output logic [SUM_W-1:0]  disp_value,
  output logic              disp_blank
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  state_t            state;
  state_t            state_nx;
  logic              valid;
  logic              accept;
  logic              last_rd;
  logic              carry;
  logic [SUM_W-1:0]  sum_raw;
  logic [SUM_W-1:0]  sum_nx;
  logic [DATA_W-1:0] max_nx;

  // State register
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic; start is only honoured while idle or finished
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start)   state_nx = READ;
      READ:  if (last_rd) state_nx = DRAIN;
      DRAIN:              state_nx = DONE;
      DONE:  if (start)   state_nx = READ;
      default:            state_nx = IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    busy    = 1'b0;
    accept  = 1'b0;
    last_rd = 1'b0;
    unique case (1'b1)
      (state == READ): begin
        busy    = 1'b1;
        last_rd = (mem_addr == LAST);
      end
      (state == DRAIN): busy = 1'b1;
      (state == IDLE),
      (state == DONE):  accept = start;
      default: ;
    endcase
  end

  // Add with carry detect; saturation pins the sum once any carry was seen
  always_comb begin
    {carry, sum_raw} = {1'b0, sum} + (SUM_W + 1)'(mem_rdata);
`ifdef SUM_SAT_EN
    sum_nx = (carry || ovf) ? '1 : sum_raw;
`else
    sum_nx = sum_raw;
`endif
    max_nx = (mem_rdata > max_val) ? mem_rdata : max_val;
  end

  // Address walk, read-valid pipe and result registers
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      mem_addr <= '0;
      valid    <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      max_val  <= '0;
      ovf      <= 1'b0;
    end else begin
      valid <= (state == READ);
      if (accept) begin
        mem_addr <= '0;
        done     <= 1'b0;
        sum      <= '0;
        max_val  <= '0;
        ovf      <= 1'b0;
      end else begin
        if ((state == READ) && !last_rd)
          mem_addr <= mem_addr + 1'b1;
        if (state == DRAIN)
          done <= 1'b1;
        if (valid) begin
          sum     <= sum_nx;
          max_val <= max_nx;
          ovf     <= ovf | carry;
        end
      end
    end
  end

  // Display mux straight from registers
  always_comb begin
    disp_value = disp_sel ? SUM_W'(max_val) : sum;
    disp_blank = busy;
  end

endmodule

// File: doc/sum_seq_ctrl.md
Name: sum_seq_ctrl

Overview:
- Controller that sequences a synchronous word memory (ROM/RAM read port, 1-cycle read latency) into a running sum.
- On a start pulse it walks addresses 0..NUM_WORDS-1, accumulates each word, tracks the maximum word, then flags done.
- Drives a display value selected by a slide switch; sits between the memory and the seven-segment decode in ChipInterface.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 8, memory word width.
- SUM_W, 16, accumulator width (SUM_W >= DATA_W).
- NUM_WORDS, 10, words summed per run (1..2**ADDR_W).

Ports:
- clock  in  1  system clock, rising edge.
- resetN  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled at clock edges.
- mem_addr  out  ADDR_W  read address to memory.
- mem_rdata  in  DATA_W  memory data, valid the cycle after mem_addr is registered by memory.
- busy  out  1  run in progress.
- done  out  1  run complete, held until next accepted start or reset.
- sum  out  SUM_W  accumulated sum.
- max_val  out  DATA_W  largest word seen this run.
- ovf  out  1  sum exceeded 2**SUM_W-1 during the run (sticky per run).
- disp_sel  in  1  display select.
- disp_value  out  SUM_W  value for HEX decode.
- disp_blank  out  1  blank display request.

Behaviour:
- Reset (async, resetN=0): state IDLE; mem_addr=0, busy=0, done=0, sum=0, max_val=0, ovf=0, internal valid pipe=0. Takes effect immediately, including mid-run; the run is abandoned, no partial done.
- States: IDLE, READ, DRAIN, DONE.
- IDLE/DONE with start=1 at edge E0: sum<=0, max_val<=0, ovf<=0, done<=0, mem_addr<=0, state<=READ. start while READ/DRAIN is ignored.
- READ: each edge mem_addr increments. At the edge where mem_addr==NUM_WORDS-1, mem_addr holds and state<=DRAIN.
- Valid pipe: 1-bit registered flag marks mem_rdata valid. It is set for the cycle after each READ-state cycle.
- Each edge with valid=1: sum<=sum+mem_rdata (zero-extended), max_val<=max(max_val,mem_rdata), ovf|=carry out of SUM_W.
- DRAIN: one edge accumulates the last word; state<=DONE, done<=1.
- Timing: done rises after edge E(NUM_WORDS+1), counting E0 as the start-sampling edge. busy=1 exactly in READ and DRAIN. NUM_WORDS=1 goes READ->DRAIN on E1, with done after E2.
- Arithmetic: wraps modulo 2**SUM_W by default.
- disp_value: disp_sel=0 gives sum; disp_sel=1 gives max_val zero-extended. Combinational from registers. disp_blank=busy.
- DONE with start=1: identical to IDLE start; done drops at E0.

Optional Feature:
- Macro SUM_SAT_EN.
- Defined: on carry out, sum saturates to all ones and stays saturated for the rest of the run; ovf=1.
- Undefined: sum wraps modulo 2**SUM_W; ovf still set on carry.

Test Plan:
- NUM_WORDS=4, mem {3,5,7,9}, 1-cycle start pulse -> busy for 5 cycles; done after E5; sum=0x0018, max_val=9, ovf=0; disp_sel=0 gives 0x0018, disp_sel=1 gives 0x0009.
- SUM_W=8, NUM_WORDS=4, mem {200,100,0,0} -> without SUM_SAT_EN sum=0x2C, ovf=1; with SUM_SAT_EN sum=0xFF, ovf=1.
- start pulsed again at E2 of a run -> ignored; result and done timing identical to the first scenario.
- resetN pulsed low mid-READ (E2) -> all outputs 0 immediately, state IDLE. A subsequent start yields sum=0x0018.
- Back-to-back: start asserted in DONE -> done drops at E0, sum restarts from 0 and finishes with sum=0x0018 again.
- NUM_WORDS=1, mem {0x7F} -> busy for 2 cycles, done after E2, sum=0x007F, max_val=0x7F.
